// File: rtl/code_search_ctrl.sv
// rtl/code_search_ctrl.sv - code-phase acquisition sweep sequencer for one tracking channel
//
// Loads the PRN key, then steps code phase in STEP_HC half-chip slews. At each
// bin it discards SETTLE_DUMPS dumps, integrates energy over the dwell dumps,
// and keeps the strongest bin and a threshold-hit flag.
//
// Optional feature: define CODE_SEARCH_EARLY_EXIT_EN to stop the sweep at the
// first bin whose integrated energy meets the threshold.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start, abort               one-cycle control pulses
//   prn_key_in, dwell_dumps    sweep setup, latched on start
//   threshold                  detection threshold on integrated energy
//   dump_enable                dump pulse from the code generator
//   energy, energy_valid       prompt I^2+Q^2 and its strobe
//   prn_key, prn_key_enable    key and load pulse to the code generator
//   code_slew, slew_enable     slew value and write pulse to the code generator
//   busy, done                 sweep in progress, end-of-sweep pulse
//   found, best_bin,
//   best_energy                sweep result
module code_search_ctrl #(
  parameter int NUM_BINS     = 2046,
  parameter int STEP_HC      = 1,
  parameter int SETTLE_DUMPS = 2,
  parameter int EW           = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [9:0]    prn_key_in,
  input  logic [7:0]    dwell_dumps,
  input  logic [EW+7:0] threshold,
  input  logic          dump_enable,
  input  logic [EW-1:0] energy,
  input  logic          energy_valid,
  output logic [9:0]    prn_key,
  output logic          prn_key_enable,
  output logic [10:0]   code_slew,
  output logic          slew_enable,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [11:0]   best_bin,
  output logic [EW+7:0] best_energy
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_DUMPS - 1);
  localparam logic [11:0] LAST_BIN    = 12'(NUM_BINS - 1);
  localparam logic [10:0] STEP        = 11'(STEP_HC);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SLEW, S_SETTLE, S_DWELL, S_EVAL, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    prn_key_q, prn_key_d;
  logic [10:0]   code_slew_q, code_slew_d;
  logic [11:0]   bin_cnt_q, bin_cnt_d;
  logic [11:0]   best_bin_q, best_bin_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [7:0]    dump_cnt_q, dump_cnt_d;
  logic [EW+7:0] acc_q, acc_d;
  logic [EW+7:0] best_energy_q, best_energy_d;
  logic          found_q, found_d;

  logic settle_last, dwell_last, last_bin, hit, better, abort_act;

  assign settle_last = dump_enable && (dump_cnt_q == SETTLE_LAST);
  assign dwell_last  = dump_enable && (dump_cnt_q == dwell_q - 8'd1);
  assign last_bin    = (bin_cnt_q == LAST_BIN);
  assign hit         = (acc_q >= threshold);
  assign better      = (acc_q > best_energy_q);
  // Abort is meaningless in IDLE and redundant in DONE (already ending).
  assign abort_act   = abort && (state_q != S_IDLE) && (state_q != S_DONE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      prn_key_q     <= '0;
      code_slew_q   <= '0;
      bin_cnt_q     <= '0;
      best_bin_q    <= '0;
      dwell_q       <= '0;
      dump_cnt_q    <= '0;
      acc_q         <= '0;
      best_energy_q <= '0;
      found_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prn_key_q     <= prn_key_d;
      code_slew_q   <= code_slew_d;
      bin_cnt_q     <= bin_cnt_d;
      best_bin_q    <= best_bin_d;
      dwell_q       <= dwell_d;
      dump_cnt_q    <= dump_cnt_d;
      acc_q         <= acc_d;
      best_energy_q <= best_energy_d;
      found_q       <= found_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SLEW:   state_d = S_SETTLE;
      S_SETTLE: if (settle_last) state_d = S_DWELL;
      S_DWELL:  if (dwell_last) state_d = S_EVAL;
      S_EVAL: begin
`ifdef CODE_SEARCH_EARLY_EXIT_EN
        state_d = (hit || last_bin) ? S_DONE : S_SLEW;
`else
        state_d = last_bin ? S_DONE : S_SLEW;
`endif
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_DONE;
  end

  // Datapath updates
  always_comb begin
    prn_key_d     = prn_key_q;
    code_slew_d   = code_slew_q;
    bin_cnt_d     = bin_cnt_q;
    best_bin_d    = best_bin_q;
    dwell_d       = dwell_q;
    dump_cnt_d    = dump_cnt_q;
    acc_d         = acc_q;
    best_energy_d = best_energy_q;
    found_d       = found_q;
    case (state_q)
      S_IDLE: if (start) begin
        prn_key_d     = prn_key_in;
        code_slew_d   = STEP;
        dwell_d       = (dwell_dumps == 8'd0) ? 8'd1 : dwell_dumps;
        bin_cnt_d     = '0;
        best_bin_d    = '0;
        best_energy_d = '0;
        found_d       = 1'b0;
        dump_cnt_d    = '0;
      end
      S_SETTLE: if (dump_enable) begin
        if (settle_last) begin
          dump_cnt_d = '0;
          acc_d      = '0;
        end else begin
          dump_cnt_d = dump_cnt_q + 8'd1;
        end
      end
      S_DWELL: begin
        // Energy coincident with the final dump is still accumulated here.
        if (energy_valid) acc_d = acc_q + {8'd0, energy};
        if (dump_enable) dump_cnt_d = dwell_last ? 8'd0 : dump_cnt_q + 8'd1;
      end
      S_EVAL: if (!abort) begin
`ifdef CODE_SEARCH_EARLY_EXIT_EN
        if (hit) begin
          best_energy_d = acc_q;
          best_bin_d    = bin_cnt_q;
          found_d       = 1'b1;
        end else begin
          if (better) begin
            best_energy_d = acc_q;
            best_bin_d    = bin_cnt_q;
          end
          if (!last_bin) bin_cnt_d = bin_cnt_q + 12'd1;
        end
`else
        // Strict compare: a tie keeps the earlier bin.
        if (better) begin
          best_energy_d = acc_q;
          best_bin_d    = bin_cnt_q;
        end
        if (hit) found_d = 1'b1;
        if (!last_bin) bin_cnt_d = bin_cnt_q + 12'd1;
`endif
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    prn_key        = prn_key_q;
    code_slew      = code_slew_q;
    prn_key_enable = (state_q == S_LOAD);
    slew_enable    = (state_q == S_SLEW);
    busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    done           = (state_q == S_DONE);
    found          = found_q;
    best_bin       = best_bin_q;
    best_energy    = best_energy_q;
  end

endmodule

// File: tb/tb_code_search_ctrl.sv
// tb/tb_code_search_ctrl.sv - self-checking bench for code_search_ctrl
module tb_code_search_ctrl;

  localparam int NB = 8;
  localparam int EW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [9:0]    prn_key_in = '0;
  logic [7:0]    dwell_dumps = '0;
  logic [EW+7:0] threshold = '0;
  logic          dump_enable = 1'b0;
  logic [EW-1:0] energy = '0;
  logic          energy_valid = 1'b0;
  logic [9:0]    prn_key;
  logic          prn_key_enable;
  logic [10:0]   code_slew;
  logic          slew_enable;
  logic          busy;
  logic          done;
  logic          found;
  logic [11:0]   best_bin;
  logic [EW+7:0] best_energy;

  code_search_ctrl #(.NUM_BINS(NB), .STEP_HC(1), .SETTLE_DUMPS(2), .EW(EW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .prn_key_in(prn_key_in), .dwell_dumps(dwell_dumps), .threshold(threshold),
    .dump_enable(dump_enable), .energy(energy), .energy_valid(energy_valid),
    .prn_key(prn_key), .prn_key_enable(prn_key_enable), .code_slew(code_slew),
    .slew_enable(slew_enable), .busy(busy), .done(done), .found(found),
    .best_bin(best_bin), .best_energy(best_energy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-bin energy seen by the correlator; the bin follows the slews issued.
  int unsigned bin_e[NB];
  bit gen_en = 1'b1;
  int cyc = 0;
  int prnen_cnt = 0, slew_cnt = 0, slew_bad = 0, done_cnt = 0, dump_since = 0;

  // Dump every 5 cycles, energy strobed on the same cycle as the dump.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (gen_en && (cyc % 5 == 0)) begin
      dump_enable  = 1'b1;
      energy_valid = 1'b1;
      energy       = bin_e[(slew_cnt > NB - 1) ? NB - 1 : slew_cnt];
    end else begin
      dump_enable  = 1'b0;
      energy_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (prn_key_enable) prnen_cnt++;
    if (slew_enable) begin
      slew_cnt++;
      dump_since = 0;
      if (code_slew !== 11'd1) slew_bad++;
    end
    if (dump_enable) dump_since++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integrated energy per bin is dwell*E[b]; scan bins in order.
  task automatic model(input int dwell, input longint thr, input int limit,
                       output bit f, output int bb, output longint be, output int slews);
    int d;
    longint acc;
    d = (dwell == 0) ? 1 : dwell;
    f = 0; bb = 0; be = 0; slews = limit - 1;
    for (int b = 0; b < limit; b++) begin
      acc = longint'(d) * longint'(bin_e[b]);
`ifdef CODE_SEARCH_EARLY_EXIT_EN
      if (acc >= thr) begin
        f = 1; be = acc; bb = b; slews = b;
        break;
      end
`endif
      if (acc > be) begin be = acc; bb = b; end
      if (acc >= thr) f = 1;
    end
  endtask

  task automatic run_sweep(input string nm, input logic [9:0] key, input int dwell,
                           input longint thr, input int abort_bin);
    bit ef;
    int eb, es, i;
    longint ee;
    if (abort_bin >= 0) begin
      model(dwell, thr, abort_bin, ef, eb, ee, es);
      es = abort_bin;
    end else begin
      model(dwell, thr, NB, ef, eb, ee, es);
    end
    @(posedge clk); #1;
    prnen_cnt = 0; slew_cnt = 0; slew_bad = 0; done_cnt = 0; dump_since = 0;
    prn_key_in = key; dwell_dumps = 8'(dwell); threshold = 40'(thr); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_rise"}, busy, 1);
    chk({nm, "_prn_key_en"}, prn_key_enable, 1);
    chk({nm, "_prn_key"}, prn_key, key);
    // start while busy must be ignored
    repeat (7) @(posedge clk);
    #1; start = 1'b1; prn_key_in = ~key;
    @(posedge clk); #1; start = 1'b0; prn_key_in = key;
    if (abort_bin >= 0) begin
      i = 0;
      while (!(slew_cnt == abort_bin && dump_since >= 3) && i < 20000) begin
        @(negedge clk); #1; i++;
      end
      chk({nm, "_abort_point_reached"}, i < 20000, 1);
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      chk({nm, "_done_after_abort"}, done, 1);
    end
    i = 0;
    while (done_cnt == 0 && i < 20000) begin
      @(negedge clk); #1; i++;
    end
    chk({nm, "_done_seen"}, done_cnt > 0, 1);
    repeat (12) @(negedge clk);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_prn_key_en_count"}, prnen_cnt, 1);
    chk({nm, "_slew_count"}, slew_cnt, es);
    chk({nm, "_slew_value_bad"}, slew_bad, 0);
    chk({nm, "_found"}, found, ef);
    chk({nm, "_best_bin"}, best_bin, eb);
    chk({nm, "_best_energy"}, best_energy, ee);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_code_slew_hold"}, code_slew, 1);
    chk({nm, "_prn_key_hold"}, prn_key, key);
  endtask

  initial begin
    int d;
    longint thr;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_prn_key", prn_key, 0);
    chk("rst_prn_key_en", prn_key_enable, 0);
    chk("rst_code_slew", code_slew, 0);
    chk("rst_slew_en", slew_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_best_bin", best_bin, 0);
    chk("rst_best_energy", best_energy, 0);
    @(posedge clk); #1; rstn = 1'b1;

    // Abort while idle is ignored
    @(posedge clk); #1; done_cnt = 0; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_abort_done", done_cnt, 0);
    chk("idle_abort_busy", busy, 0);

    // Strong bin 5
    for (int b = 0; b < NB; b++) bin_e[b] = 100;
    bin_e[5] = 900;
    run_sweep("peak5", 10'h3EC, 2, 1000, -1);

    // No signal: flat energy, tie keeps bin 0
    bin_e[5] = 100;
    run_sweep("flat", 10'h155, 2, 1000, -1);

    // dwell 0 behaves as 1
    for (int b = 0; b < NB; b++) bin_e[b] = $urandom_range(1, 3000);
    run_sweep("dwell0", 10'h0A3, 0, 2500, -1);

    // Abort during DWELL of bin 3
    for (int b = 0; b < NB; b++) bin_e[b] = $urandom_range(1, 3000);
    run_sweep("abort3", 10'h2B1, 2, 64'h7FFF_FFFF_FF, 3);

    // Randomized sweeps
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < NB; b++) bin_e[b] = $urandom_range(0, 3000);
      d = $urandom_range(0, 4);
      thr = longint'((d == 0) ? 1 : d) * longint'($urandom_range(500, 3500));
      run_sweep($sformatf("rand%0d", r), 10'($urandom), d, thr, -1);
    end

    // Asynchronous reset mid-sweep: immediate return to idle, no done
    for (int b = 0; b < NB; b++) bin_e[b] = 700;
    @(posedge clk); #1;
    prn_key_in = 10'h1F0; dwell_dumps = 8'd2; threshold = 40'hFF_FFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (40) @(posedge clk);
    #2; done_cnt = 0;
    chk("pre_reset_best_energy", best_energy, 1400);
    rstn = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_best_energy", best_energy, 0);
    chk("areset_prn_key", prn_key, 0);
    chk("areset_code_slew", code_slew, 0);
    repeat (5) @(negedge clk);
    chk("areset_no_done", done_cnt, 0);
    @(posedge clk); #1; rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("areset_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
